div: RTL and testbench

//   Multi-cycle radix-2 restoring divider sequencer for the EX stage. EX raises start_i on
//   DIV/DIVU, stalls the pipeline until ready_o, then writes result_o to HI/LO
//   (HI = remainder, LO = quotient). It owns the iteration FSM, counter and operand/result

---
 rtl/div.sv | 144 ++++++++++++++
 tb/tb_div.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Radix-2 restoring divider sequencer; result_o = {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_BYZERO, S_ON, S_END
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               sgnq_q, sgnq_d;
  logic               sgnr_q, sgnr_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               rdy_q, rdy_d;

  logic               a_neg, b_neg, ge;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   rem_n, quo_n;
  logic [WIDTH:0]     shf, diff;

  always_comb begin
    a_neg = signed_div_i & opdata1_i[WIDTH-1];
    b_neg = signed_div_i & opdata2_i[WIDTH-1];
    a_abs = a_neg ? -opdata1_i : opdata1_i;
    b_abs = b_neg ? -opdata2_i : opdata2_i;
    // One restoring step on {rem, dvd}; extra bit keeps the compare exact
    shf   = {rem_q, dvd_q[WIDTH-1]};
    diff  = shf - {1'b0, dsr_q};
    ge    = shf >= {1'b0, dsr_q};
    rem_n = ge ? diff[WIDTH-1:0] : shf[WIDTH-1:0];
    quo_n = {dvd_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    res_d   = res_q;
    rdy_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        res_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_abs < b_abs) begin
            state_d = S_END;
            res_d   = {opdata1_i, {WIDTH{1'b0}}};
          end
`endif
          else begin
            state_d = S_ON;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = a_abs;
            dsr_d   = b_abs;
            sgnq_d  = a_neg ^ b_neg;
            sgnr_d  = a_neg;
          end
        end
      end
      S_BYZERO: begin
        res_d   = '0;
        state_d = annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_n;
          dvd_d = quo_n;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_END;
            res_d   = {sgnr_q ? -rem_n : rem_n,
                       sgnq_q ? -quo_n : quo_n};
          end
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
          res_d   = '0;
        end else begin
          rdy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  end

  assign result_o = res_q;
  assign ready_o  = rdy_q;
  assign busy_o   = (state_q == S_BYZERO) || (state_q == S_ON);

endmodule

// File: tb/tb_div.sv
// Directed vector bench for div: table of divisions plus
// annul, reset and END-hold sequences.
module tb_div;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (sgn),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    string       nm;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
    bit          eo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic run_div(input string nm, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] er, input int el);
    int n;
    bit got;
    @(negedge clk);
    sgn = s; op1 = a; op2 = b; start = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        got = 1'b1;
      end else begin
        if (n == 0) begin
          chk({nm, "_busy"}, 64'(busy_o), 64'(el > 1));
          op1 = $urandom;
          op2 = $urandom;
          sgn = ~s;
        end
        n++;
      end
    end
    chk({nm, "_lat"}, got ? 64'(n) : 64'hDEAD, 64'(el));
    if (got) begin
      chk({nm, "_res"}, result_o, er);
      @(posedge clk);
      #1;
      chk({nm, "_hold"}, {result_o[62:0], ready_o}, {er[62:0], 1'b1});
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({nm, "_drop"}, {result_o[62:0], ready_o}, 64'h0);
    end else begin
      start = 1'b0;
      @(posedge clk);
    end
  endtask

  initial begin
    int n;
    bit seen;
    vecs[0] = '{"divu100_7", 1'b0, 32'd100, 32'd7,
                64'h00000002_0000000E, 33, 1'b0};
    vecs[1] = '{"divm7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
                64'hFFFFFFFF_FFFFFFFD, 33, 1'b0};
    vecs[2] = '{"div7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
                64'h00000001_FFFFFFFD, 33, 1'b0};
    vecs[3] = '{"div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
                64'h00000000_80000000, 33, 1'b0};
    vecs[4] = '{"div5_0", 1'b1, 32'd5, 32'd0,
                64'h0, 2, 1'b0};
    vecs[5] = '{"divu3_10", 1'b0, 32'd3, 32'd10,
                64'h00000003_00000000, 33, 1'b1};
    vecs[6] = '{"divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1,
                64'h00000000_FFFFFFFF, 33, 1'b0};
    vecs[7] = '{"divu_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                64'h00000000_00000001, 33, 1'b0};
    vecs[8] = '{"divm100_7", 1'b1, 32'hFFFFFF9C, 32'd7,
                64'hFFFFFFFE_FFFFFFF2, 33, 1'b0};
    vecs[9] = '{"divu_big_small", 1'b0, 32'h80000000, 32'hFFFFFFFF,
                64'h80000000_00000000, 33, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset", {result_o[61:0], ready_o, busy_o}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].nm, vecs[i].s, vecs[i].a, vecs[i].b,
              vecs[i].res, (vecs[i].eo && EO) ? 1 : vecs[i].lat);
    end

    // annul during iteration 10
    @(negedge clk);
    sgn = 1'b0; op1 = 32'd123; op2 = 32'd4; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("annul_pre_busy", 64'(busy_o), 64'h1);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    chk("annul_idle", {result_o[61:0], ready_o, busy_o}, 64'h0);
    annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    chk("annul_no_ready", 64'(seen), 64'h0);
    run_div("divu9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // reset during iteration 20
    @(negedge clk);
    sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_pre_busy", 64'(busy_o), 64'h1);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid", {result_o[61:0], ready_o, busy_o}, 64'h0);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_after", {result_o[61:0], ready_o, busy_o}, 64'h0);

    // annul while parked in END with start held
    @(negedge clk);
    sgn = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("end_ready", {result_o, ready_o} == {64'h00000000_0000000A, 1'b1}
                     ? 64'h1 : 64'h0, 64'h1);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    chk("end_annul", {result_o[62:0], ready_o}, 64'h0);
    @(posedge clk);
    #1;
    chk("end_annul_idle", {result_o[61:0], ready_o, busy_o}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
